dtree_sample_sequencer: RTL

Sequential front end for the combinational printed decision-tree classifiers. It takes feature bytes from a serial valid/ready stream in any order and assembles a complete feature vector. It then holds that vector stable on the tree inputs for a programmable settle time, captures the class code, and returns it on a valid/ready output stream. It sits between the sensor/feature bus and one tree instance.

---
 rtl/dtree_seq_pkg.sv | 29 ++
 rtl/dtree_cycle_counter.sv | 36 +++
 rtl/dtree_sample_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dtree_seq_pkg.sv
// Shared types and constants for the decision-tree sample sequencer.
// Holds the sequencer state encoding, default widths and the slot-mask helper.
package dtree_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_HOLD    = 2'd3
    } seq_state_e;

    localparam int DEF_N_FEAT = 5;
    localparam int DEF_FEAT_W = 8;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_CLS_W  = 5;

    // Mask with one bit set per feature slot; vectors wider than 32 slots are unsupported.
    function automatic logic [31:0] full_mask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dtree_cycle_counter.sv
// Loadable down-counter with a zero flag; it saturates at zero while enabled.
// Used for the settle delay and, when enabled, the partial-vector timeout.
module dtree_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dtree_sample_sequencer.sv
// Collects feature beats into a vector, holds it on the tree for a settle time, returns the class.
// Define DTREE_TIMEOUT_EN to drop partial vectors after TIMEOUT_CYC idle cycles.
module dtree_sample_sequencer
    import dtree_seq_pkg::*;
#(
    parameter int N_FEAT      = DEF_N_FEAT,
    parameter int FEAT_W      = DEF_FEAT_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int CLS_W       = DEF_CLS_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic [FEAT_W-1:0]        in_data,
    output logic [N_FEAT*FEAT_W-1:0] feat_vec,
    input  logic [CLS_W-1:0]         tree_class,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLS_W-1:0]         out_class,
    output logic                     busy,
    output logic                     err_idx,
    output logic                     err_timeout
);

    if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1 || (1 << IDX_W) < N_FEAT) begin : g_param_check
        $error("dtree_sample_sequencer: invalid parameter combination");
    end

    localparam int                SET_W      = $clog2(SETTLE_CYC + 1);
    localparam logic [31:0]       FULL32     = full_mask(N_FEAT);
    localparam logic [N_FEAT-1:0] FULL_MASK  = FULL32[N_FEAT-1:0];
    localparam logic [IDX_W:0]    N_FEAT_EXT = (IDX_W + 1)'(N_FEAT);

    seq_state_e                     state_q, state_d;
    logic [N_FEAT-1:0][FEAT_W-1:0]  feat_q, feat_d;
    logic [N_FEAT-1:0]              mask_q, mask_d;
    logic [CLS_W-1:0]               class_q, class_d;
    logic                           err_idx_q, err_idx_d;

    logic beat_acc;
    logic idx_ok;
    logic settle_load;
    logic settle_en;
    logic settle_zero;

`ifdef DTREE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic tmo_load;
    logic tmo_en;
    logic tmo_zero;
    logic err_tmo_q, err_tmo_d;
`endif

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_HOLD);
    assign feat_vec  = feat_q;
    assign out_class = class_q;
    assign err_idx   = err_idx_q;

    assign beat_acc  = in_valid && in_ready;
    assign idx_ok    = ({1'b0, in_idx} < N_FEAT_EXT);
    assign settle_en = (state_q == ST_SETTLE);

    // Out-of-range beats are consumed but only raise err_idx.
    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        mask_d      = mask_q;
        class_d     = class_q;
        err_idx_d   = 1'b0;
        settle_load = 1'b0;
`ifdef DTREE_TIMEOUT_EN
        tmo_load    = 1'b0;
        tmo_en      = 1'b0;
        err_tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (beat_acc) begin
                    if (idx_ok) begin
                        for (int k = 0; k < N_FEAT; k++) begin
                            if (in_idx == IDX_W'(k)) begin
                                feat_d[k] = in_data;
                                mask_d[k] = 1'b1;
                            end
                        end
                    end else begin
                        err_idx_d = 1'b1;
                    end
                    if (mask_d == FULL_MASK) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end
                end
`ifdef DTREE_TIMEOUT_EN
                tmo_load = beat_acc;
                tmo_en   = !beat_acc && (mask_q != '0);
                if (!beat_acc && (mask_q != '0) && tmo_zero) begin
                    mask_d    = '0;
                    err_tmo_d = 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    class_d = tree_class;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    mask_d  = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            feat_q    <= '0;
            mask_q    <= '0;
            class_q   <= '0;
            err_idx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            feat_q    <= feat_d;
            mask_q    <= mask_d;
            class_q   <= class_d;
            err_idx_q <= err_idx_d;
        end
    end

    // Loaded with SETTLE_CYC-1 on the completing beat so capture lands SETTLE_CYC edges later.
    dtree_cycle_counter #(
        .W (SET_W)
    ) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (settle_load),
        .load_val_i (SET_W'(SETTLE_CYC - 1)),
        .en_i       (settle_en),
        .zero_o     (settle_zero)
    );

`ifdef DTREE_TIMEOUT_EN
    dtree_cycle_counter #(
        .W (TMO_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmo_load),
        .load_val_i (TMO_W'(TIMEOUT_CYC - 1)),
        .en_i       (tmo_en),
        .zero_o     (tmo_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tmo_q <= 1'b0;
        end else begin
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_timeout = err_tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
